// File: rtl/nts_pkg.sv
// Shared constants, field record and helpers for the NTS header decoder.
// Used by nts_ip_decoder and nts_ip_csum16.
package nts_pkg;

    localparam logic [15:0] ETHERTYPE_IPV4     = 16'h0800;
    localparam logic [3:0]  IPV4_VERSION       = 4'd4;
    localparam logic [3:0]  IPV4_IHL           = 4'd5;
    localparam logic [15:0] IPV4_MIN_TOTAL_LEN = 16'd28;

    localparam logic [3:0] OP_ETHERTYPE      = 4'd0;
    localparam logic [3:0] OP_SRC_IP         = 4'd1;
    localparam logic [3:0] OP_DST_IP         = 4'd2;
    localparam logic [3:0] OP_LEN_IDENT      = 4'd3;
    localparam logic [3:0] OP_TTL_PROTO_CSUM = 4'd4;
    localparam logic [3:0] OP_UDP_PORTS      = 4'd5;
    localparam logic [3:0] OP_UDP_LEN_CSUM   = 4'd6;
    localparam logic [3:0] OP_WORD_COUNT     = 4'd7;
    localparam logic [3:0] OP_BYTE_COUNT     = 4'd8;
    localparam logic [3:0] OP_CSUM_SUM       = 4'd9;

    localparam logic [7:0] BV_1 = 8'h01;
    localparam logic [7:0] BV_2 = 8'h03;
    localparam logic [7:0] BV_3 = 8'h07;
    localparam logic [7:0] BV_4 = 8'h0f;
    localparam logic [7:0] BV_5 = 8'h1f;
    localparam logic [7:0] BV_6 = 8'h3f;
    localparam logic [7:0] BV_7 = 8'h7f;
    localparam logic [7:0] BV_8 = 8'hff;

    typedef struct packed {
        logic [15:0] ethertype;
        logic [7:0]  ver_ihl;
        logic [15:0] total_length;
        logic [15:0] ident;
        logic [7:0]  ttl;
        logic [7:0]  protocol;
        logic [15:0] ip_csum;
        logic [31:0] src_ip;
        logic [31:0] dst_ip;
        logic [15:0] udp_src;
        logic [15:0] udp_dst;
        logic [15:0] udp_len;
        logic [15:0] udp_csum;
    } ip_fields_t;

    // Malformed masks are treated as a full word.
    function automatic logic [3:0] valid_bytes(input logic [7:0] mask);
        case (mask)
            BV_1:    return 4'd1;
            BV_2:    return 4'd2;
            BV_3:    return 4'd3;
            BV_4:    return 4'd4;
            BV_5:    return 4'd5;
            BV_6:    return 4'd6;
            BV_7:    return 4'd7;
            default: return 4'd8;
        endcase
    endfunction

    // a+b never exceeds 0x1fffe, so folding the carry back cannot overflow again.
    function automatic logic [15:0] ones_add16(input logic [15:0] a, input logic [15:0] b);
        logic [16:0] s;
        s = {1'b0, a} + {1'b0, b};
        return s[15:0] + {15'd0, s[16]};
    endfunction

endpackage

// File: rtl/nts_ip_csum16.sv
// Ones-complement 16-bit accumulator: folds up to four halfwords per cycle
// with end-around carry; o_sum_next exposes the value being written.
module nts_ip_csum16
    import nts_pkg::*;
(
    input  logic        i_clk,
    input  logic        i_areset,
    input  logic        i_clear,
    input  logic        i_add,
    input  logic [63:0] i_halfwords,
    output logic [15:0] o_sum,
    output logic [15:0] o_sum_next
);

    always_comb begin
        o_sum_next = o_sum;
        if (i_add) begin
            for (int k = 3; k >= 0; k--) begin
                o_sum_next = ones_add16(o_sum_next, i_halfwords[16*k +: 16]);
            end
        end
    end

    always_ff @(posedge i_clk or posedge i_areset) begin
        if (i_areset) begin
            o_sum <= '0;
        end else if (i_clear) begin
            o_sum <= '0;
        end else if (i_add) begin
            o_sum <= o_sum_next;
        end
    end

endmodule

// File: rtl/nts_ip_decoder.sv
// Streaming Ethernet/IPv4/UDP header decoder with opcode read port.
// Define NTS_IP_CHECKSUM_EN to build the IPv4 header checksum check.
module nts_ip_decoder
    import nts_pkg::*;
#(
    parameter int ADDR_WIDTH = 10
) (
    input  logic        i_clk,
    input  logic        i_areset,
    input  logic        i_clear,
    input  logic        i_process,
    input  logic [7:0]  i_last_word_data_valid,
    input  logic [63:0] i_data,
    input  logic [3:0]  i_read_opcode,
    output logic        o_detect_ipv4,
    output logic        o_detect_ipv4_bad,
    output logic [31:0] o_read_data
);

    localparam logic [ADDR_WIDTH-1:0] W1 = ADDR_WIDTH'(1);
    localparam logic [ADDR_WIDTH-1:0] W2 = ADDR_WIDTH'(2);
    localparam logic [ADDR_WIDTH-1:0] W3 = ADDR_WIDTH'(3);
    localparam logic [ADDR_WIDTH-1:0] W4 = ADDR_WIDTH'(4);
    localparam logic [ADDR_WIDTH-1:0] W5 = ADDR_WIDTH'(5);

    logic [ADDR_WIDTH-1:0] word_count;
    logic [ADDR_WIDTH+3:0] byte_count;
    ip_fields_t            f;
    logic [15:0]           csum_sum;
    logic                  csum_ok;
    logic                  is_ipv4;
    logic                  hdr_bad;
    logic [31:0]           rd_mux;

`ifdef NTS_IP_CHECKSUM_EN
    logic        csum_add;
    logic [63:0] csum_words;
    logic [15:0] csum_next;

    // Header halfwords only: ver/IHL+TOS of word 1 through dst_ip low of word 4.
    always_comb begin
        csum_add   = 1'b0;
        csum_words = '0;
        if (i_process) begin
            case (word_count)
                W1: begin
                    csum_add   = 1'b1;
                    csum_words = {48'h0, i_data[15:0]};
                end
                W2, W3: begin
                    csum_add   = 1'b1;
                    csum_words = i_data;
                end
                W4: begin
                    csum_add   = 1'b1;
                    csum_words = {i_data[63:48], 48'h0};
                end
                default: ;
            endcase
        end
    end

    nts_ip_csum16 u_csum (
        .i_clk       (i_clk),
        .i_areset    (i_areset),
        .i_clear     (i_clear),
        .i_add       (csum_add),
        .i_halfwords (csum_words),
        .o_sum       (csum_sum),
        .o_sum_next  (csum_next)
    );

    assign csum_ok = (csum_next == 16'hffff);
`else
    assign csum_sum = 16'h0;
    assign csum_ok  = 1'b1;
`endif

    assign is_ipv4 = (f.ethertype == ETHERTYPE_IPV4);
    assign hdr_bad = (f.ver_ihl[7:4] != IPV4_VERSION) || (f.ver_ihl[3:0] != IPV4_IHL) ||
                     !csum_ok || (f.total_length < IPV4_MIN_TOTAL_LEN);

    always_comb begin
        rd_mux = '0;
        case (i_read_opcode)
            OP_ETHERTYPE:      rd_mux = {16'h0, f.ethertype};
            OP_SRC_IP:         rd_mux = f.src_ip;
            OP_DST_IP:         rd_mux = f.dst_ip;
            OP_LEN_IDENT:      rd_mux = {f.total_length, f.ident};
            OP_TTL_PROTO_CSUM: rd_mux = {f.ttl, f.protocol, f.ip_csum};
            OP_UDP_PORTS:      rd_mux = {f.udp_src, f.udp_dst};
            OP_UDP_LEN_CSUM:   rd_mux = {f.udp_len, f.udp_csum};
            OP_WORD_COUNT:     rd_mux = 32'(word_count);
            OP_BYTE_COUNT:     rd_mux = 32'(byte_count);
            OP_CSUM_SUM:       rd_mux = {16'h0, csum_sum};
            default:           rd_mux = '0;
        endcase
    end

    always_ff @(posedge i_clk or posedge i_areset) begin
        if (i_areset) begin
            word_count        <= '0;
            byte_count        <= '0;
            f                 <= '0;
            o_detect_ipv4     <= 1'b0;
            o_detect_ipv4_bad <= 1'b0;
            o_read_data       <= '0;
        end else if (i_clear) begin
            word_count        <= '0;
            byte_count        <= '0;
            f                 <= '0;
            o_detect_ipv4     <= 1'b0;
            o_detect_ipv4_bad <= 1'b0;
            o_read_data       <= '0;
        end else begin
            o_read_data <= rd_mux;
            if (i_process) begin
                if (word_count != '1) word_count <= word_count + 1'b1;
                byte_count <= {1'b0, word_count, 3'b000} +
                              {{ADDR_WIDTH{1'b0}}, valid_bytes(i_last_word_data_valid)};
                case (word_count)
                    W1: begin
                        f.ethertype <= i_data[31:16];
                        f.ver_ihl   <= i_data[15:8];
                    end
                    W2: begin
                        f.total_length <= i_data[63:48];
                        f.ident        <= i_data[47:32];
                        f.ttl          <= i_data[15:8];
                        f.protocol     <= i_data[7:0];
                    end
                    W3: begin
                        f.ip_csum       <= i_data[63:48];
                        f.src_ip        <= i_data[47:16];
                        f.dst_ip[31:16] <= i_data[15:0];
                    end
                    W4: begin
                        f.dst_ip[15:0]    <= i_data[63:48];
                        f.udp_src         <= i_data[47:32];
                        f.udp_dst         <= i_data[31:16];
                        f.udp_len         <= i_data[15:0];
                        o_detect_ipv4     <= is_ipv4;
                        o_detect_ipv4_bad <= is_ipv4 && hdr_bad;
                    end
                    W5: f.udp_csum <= i_data[63:48];
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_nts_ip_decoder.sv
// Randomized self-checking bench for nts_ip_decoder; the reference model
// works on packet byte offsets rather than on word-level register updates.
module tb_nts_ip_decoder;

    localparam int AW   = 10;
    localparam int WMAX = (1 << AW) - 1;
    localparam int PKT_BYTES = 8 * 1040;
`ifdef NTS_IP_CHECKSUM_EN
    localparam bit CSUM_EN = 1'b1;
`else
    localparam bit CSUM_EN = 1'b0;
`endif

    logic        i_clk = 1'b0;
    logic        i_areset;
    logic        i_clear;
    logic        i_process;
    logic [7:0]  i_last_word_data_valid;
    logic [63:0] i_data;
    logic [3:0]  i_read_opcode;
    logic        o_detect_ipv4;
    logic        o_detect_ipv4_bad;
    logic [31:0] o_read_data;

    nts_ip_decoder #(.ADDR_WIDTH(AW)) dut (
        .i_clk                  (i_clk),
        .i_areset               (i_areset),
        .i_clear                (i_clear),
        .i_process              (i_process),
        .i_last_word_data_valid (i_last_word_data_valid),
        .i_data                 (i_data),
        .i_read_opcode          (i_read_opcode),
        .o_detect_ipv4          (o_detect_ipv4),
        .o_detect_ipv4_bad      (o_detect_ipv4_bad),
        .o_read_data            (o_read_data)
    );

    always #5 i_clk = ~i_clk;

    int n_checks = 0;
    int n_errors = 0;

    logic [7:0] pkt [PKT_BYTES];
    int nwords     = 0;   // words the decoder has seen since reset/clear
    int last_bytes = 0;   // byte count credited to the last word

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // ---- reference model: a packet byte is captured iff its word (0..5) was sent
    function automatic logic [7:0] cb(input int i);
        if ((i / 8) < nwords && (i / 8) <= 5) return pkt[i];
        return 8'h0;
    endfunction

    function automatic logic [15:0] h(input int i);
        return {cb(i), cb(i + 1)};
    endfunction

    function automatic logic [15:0] model_sum();
        int unsigned s = 0;
        for (int i = 14; i < 34; i += 2) s += h(i);
        while (s > 32'hffff) s = (s & 32'hffff) + (s >> 16);
        return s[15:0];
    endfunction

    function automatic logic [31:0] model_read(input int op);
        int wc = (nwords > WMAX) ? WMAX : nwords;
        int bi = (nwords - 1 > WMAX) ? WMAX : nwords - 1;
        case (op)
            0: return {16'h0, h(12)};
            1: return {h(26), h(28)};
            2: return {h(30), h(32)};
            3: return {h(16), h(18)};
            4: return {cb(22), cb(23), h(24)};
            5: return {h(34), h(36)};
            6: return {h(38), h(40)};
            7: return wc;
            8: return (nwords == 0) ? 0 : 8 * bi + last_bytes;
            9: return CSUM_EN ? {16'h0, model_sum()} : 32'h0;
            default: return 32'h0;
        endcase
    endfunction

    function automatic bit model_ipv4();
        return (nwords >= 5) && (h(12) == 16'h0800);
    endfunction

    function automatic bit model_bad();
        return model_ipv4() && ((cb(14) != 8'h45) || (CSUM_EN && model_sum() != 16'hffff) ||
                                (h(16) < 16'd28));
    endfunction

    // ---- stimulus helpers
    task automatic make_frame(input logic [15:0] eth, input logic [7:0] verihl,
                              input logic [15:0] tl, input logic [31:0] src,
                              input logic [31:0] dst, input bit good);
        int unsigned s = 0;
        logic [15:0] c;
        for (int i = 0; i < PKT_BYTES; i++) pkt[i] = 8'($urandom);
        {pkt[12], pkt[13]} = eth;
        pkt[14] = verihl;
        {pkt[16], pkt[17]} = tl;
        {pkt[26], pkt[27], pkt[28], pkt[29]} = src;
        {pkt[30], pkt[31], pkt[32], pkt[33]} = dst;
        pkt[24] = 8'h0;
        pkt[25] = 8'h0;
        for (int i = 14; i < 34; i += 2) s += {pkt[i], pkt[i + 1]};
        while (s > 32'hffff) s = (s & 32'hffff) + (s >> 16);
        c = ~s[15:0];
        {pkt[24], pkt[25]} = c;
        if (!good) pkt[25] = pkt[25] ^ 8'h01;
    endtask

    task automatic send(input int nw, input int lb, input bit badmask, input int maxgap);
        logic [63:0] d;
        logic [7:0]  m;
        for (int w = 0; w < nw; w++) begin
            d = '0;
            for (int b = 0; b < 8; b++) d = {d[55:0], pkt[8 * w + b]};
            m = 8'hff;
            if (w == nw - 1) begin
                if (badmask) begin
                    case ($urandom_range(0, 3))
                        0: m = 8'h05;
                        1: m = 8'hf0;
                        2: m = 8'h81;
                        default: m = 8'hfe;
                    endcase
                end else begin
                    m = 8'((1 << lb) - 1);
                end
            end
            i_data = d;
            i_last_word_data_valid = m;
            i_process = 1'b1;
            @(negedge i_clk);
            i_process = 1'b0;
            if (maxgap > 0) repeat ($urandom_range(0, maxgap)) @(negedge i_clk);
        end
        nwords = nwords + nw;
        last_bytes = badmask ? 8 : lb;
    endtask

    task automatic read_op(input int op, output logic [31:0] v);
        i_read_opcode = 4'(op);
        @(negedge i_clk);
        v = o_read_data;
    endtask

    task automatic check_all(input string tag);
        logic [31:0] v;
        int op;
        chk({tag, " ipv4"}, {31'h0, o_detect_ipv4}, {31'h0, model_ipv4()});
        chk({tag, " bad"}, {31'h0, o_detect_ipv4_bad}, {31'h0, model_bad()});
        for (int k = 0; k <= 10; k++) begin
            op = (k == 10) ? $urandom_range(10, 15) : k;
            read_op(op, v);
            chk($sformatf("%s op%0d", tag, op), v, model_read(op));
        end
    endtask

    task automatic do_clear();
        i_clear = 1'b1;
        @(negedge i_clk);
        i_clear = 1'b0;
        nwords = 0;
        last_bytes = 0;
    endtask

    initial begin
        logic [31:0] v;
        i_areset = 1'b1;
        i_clear = 1'b0;
        i_process = 1'b0;
        i_last_word_data_valid = 8'hff;
        i_data = '0;
        i_read_opcode = '0;
        repeat (3) @(negedge i_clk);
        i_areset = 1'b0;
        check_all("reset");

        // reference IPv4/UDP frame
        make_frame(16'h0800, 8'h45, 16'h004c, 32'h0a000001, 32'h0a000002, 1'b1);
        send(8, 6, 1'b0, 0);
        check_all("valid");
        chk("valid ipv4 const", {31'h0, o_detect_ipv4}, 32'd1);
        chk("valid bad const", {31'h0, o_detect_ipv4_bad}, 32'd0);
        read_op(7, v); chk("valid wc const", v, 32'd8);
        read_op(8, v); chk("valid bc const", v, 32'd62);
        read_op(1, v); chk("valid src const", v, 32'h0a000001);
        read_op(2, v); chk("valid dst const", v, 32'h0a000002);
        do_clear();

        make_frame(16'h0800, 8'h45, 16'h004c, 32'h0a000001, 32'h0a000002, 1'b0);
        send(8, 6, 1'b0, 1);
        check_all("csum flip");
        chk("csum flip bad const", {31'h0, o_detect_ipv4_bad}, {31'h0, CSUM_EN});
        do_clear();

        make_frame(16'h86dd, 8'h60, 16'h004c, 32'h0a000001, 32'h0a000002, 1'b1);
        send(8, 8, 1'b0, 0);
        check_all("ipv6");
        read_op(0, v); chk("ipv6 ethertype const", v, 32'h000086dd);
        do_clear();

        make_frame(16'h0800, 8'h46, 16'h004c, 32'h0a000001, 32'h0a000002, 1'b1);
        send(8, 8, 1'b0, 0);
        check_all("ihl6");
        chk("ihl6 bad const", {31'h0, o_detect_ipv4_bad}, 32'd1);
        do_clear();

        // runt, then clear that collides with a new word
        make_frame(16'h0800, 8'h45, 16'h004c, 32'h0a000001, 32'h0a000002, 1'b1);
        send(3, 8, 1'b0, 0);
        check_all("runt");
        i_clear = 1'b1;
        i_process = 1'b1;
        i_data = {$urandom, $urandom};
        @(negedge i_clk);
        i_clear = 1'b0;
        i_process = 1'b0;
        nwords = 0;
        last_bytes = 0;
        check_all("clear+process");

        // reset in the middle of a frame
        make_frame(16'h0800, 8'h45, 16'h0100, $urandom, $urandom, 1'b1);
        send(3, 8, 1'b0, 0);
        #2 i_areset = 1'b1;
        @(negedge i_clk);
        i_areset = 1'b0;
        nwords = 0;
        last_bytes = 0;
        make_frame(16'h0800, 8'h45, 16'h0100, $urandom, $urandom, 1'b1);
        send(8, 8, 1'b0, 1);
        check_all("post reset");
        do_clear();

        for (int t = 0; t < 40; t++) begin
            make_frame(($urandom_range(0, 3) != 0) ? 16'h0800 : 16'($urandom),
                       ($urandom_range(0, 3) != 0) ? 8'h45 : 8'($urandom),
                       $urandom_range(0, 1) ? 16'($urandom_range(28, 1500))
                                            : 16'($urandom_range(0, 40)),
                       $urandom, $urandom, $urandom_range(0, 3) != 0);
            send($urandom_range(1, 12), $urandom_range(1, 8), $urandom_range(0, 5) == 0, 2);
            check_all($sformatf("rand%0d", t));
            do_clear();
        end

        // word counter saturation
        make_frame(16'h0800, 8'h45, 16'h004c, 32'h0a000001, 32'h0a000002, 1'b1);
        send(1030, 3, 1'b0, 0);
        check_all("overrun");

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
